sprite_line_renderer: RTL and testbench

- Scanline sprite compositor sitting directly downstream of ship_rom and the sprite_romA/B/C enemy ROMs.
- During horizontal blanking, for the next scanline, it walks a table of sprite objects, drives the shared ROM address and select, and captures the returned row bits.
- It paints opaque pixels into a double-buffered 640-entry line buffer.
- During active video it streams the previously rendered line to the colour mapper as pix_on/pix_type.

---
 rtl/sprite_pkg.sv | 42 ++++
 rtl/sprite_line_buffer.sv | 55 +++++
 rtl/sprite_line_renderer.sv | 206 ++++++++++++++++++++
 tb/tb_sprite_line_renderer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the scanline sprite compositor.
//   spr_type_t     : sprite/ROM type, doubles as the ROM select code
//   lb_entry_t     : one line-buffer pixel {valid, kind}
//   render_state_t : render FSM states
package sprite_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned SPR_H    = 8;
  localparam int unsigned SHIP_W   = 16;
  localparam int unsigned ENEMY_W  = 8;
  localparam int unsigned X_W      = 10;
  localparam int unsigned ROM_W    = 16;
  localparam int unsigned COL_W    = 5;
  localparam int unsigned LB_AW    = $clog2(H_ACTIVE);

  typedef enum logic [1:0] {
    SPR_A    = 2'd0,
    SPR_B    = 2'd1,
    SPR_C    = 2'd2,
    SPR_SHIP = 2'd3
  } spr_type_t;

  typedef struct packed {
    logic      valid;
    spr_type_t kind;
  } lb_entry_t;

  typedef enum logic [2:0] {
    RS_IDLE  = 3'd0,
    RS_EVAL  = 3'd1,
    RS_FETCH = 3'd2,
    RS_WRITE = 3'd3,
    RS_NEXT  = 3'd4,
    RS_DONE  = 3'd5
  } render_state_t;

  // Pixel width of a sprite row for a given type.
  function automatic logic [COL_W-1:0] spr_width(input spr_type_t t);
    return (t == SPR_SHIP) ? COL_W'(SHIP_W) : COL_W'(ENEMY_W);
  endfunction

endpackage

// File: rtl/sprite_line_buffer.sv
// Double-buffered scanline pixel store.
//   clk_i, rst_ni : clock, async active-low reset (read register only)
//   bank_sel_i    : index of the front (display) bank; the other is the back bank
//   rd_en_i       : read-and-clear front[rd_addr_i] this cycle
//   rd_gate_i     : when low the registered read returns an empty entry
//   rd_entry_o    : registered read data, one cycle after the request
//   wr_en_i/wr_addr_i/wr_entry_i : write port into the back bank
module sprite_line_buffer
  import sprite_pkg::*;
#(
  parameter int unsigned DEPTH  = H_ACTIVE,
  parameter int unsigned ADDR_W = LB_AW
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              bank_sel_i,
  input  logic              rd_en_i,
  input  logic              rd_gate_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output lb_entry_t         rd_entry_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  lb_entry_t         wr_entry_i
);

  lb_entry_t bank0_q [DEPTH];
  lb_entry_t bank1_q [DEPTH];
  lb_entry_t rd_entry_q;

  // Each bank takes at most one write per cycle: the clear when it is
  // front, the render write when it is back.
  always_ff @(posedge clk_i) begin
    if (bank_sel_i == 1'b0) begin
      if (rd_en_i) bank0_q[rd_addr_i] <= '0;
      if (wr_en_i) bank1_q[wr_addr_i] <= wr_entry_i;
    end else begin
      if (rd_en_i) bank1_q[rd_addr_i] <= '0;
      if (wr_en_i) bank0_q[wr_addr_i] <= wr_entry_i;
    end
  end

  // Registered front-bank read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_entry_q <= '0;
    end else if (rd_en_i && rd_gate_i) begin
      rd_entry_q <= bank_sel_i ? bank1_q[rd_addr_i] : bank0_q[rd_addr_i];
    end else begin
      rd_entry_q <= '0;
    end
  end

  assign rd_entry_o = rd_entry_q;

endmodule

// File: rtl/sprite_line_renderer.sv
// Scanline sprite compositor: renders the next line into the back bank
// during hblank while the front bank streams to the colour mapper.
//   Clk, Reset_n        : clock, async active-low reset
//   line_start, next_y  : swap banks and render line next_y
//   spr_x/y/en/type     : sprite table, slot i at field i (slot 0 wins)
//   rom_sel, rom_addr   : shared sprite ROM select and row address
//   rom_data            : ROM row, combinational from rom_sel/rom_addr
//   draw_x              : display x; pix_on/pix_type follow one cycle later
//   busy, overflow      : render in progress / render aborted by line_start
module sprite_line_renderer
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_SPR = 8
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   line_start,
  input  logic [X_W-1:0]         next_y,
  input  logic [NUM_SPR*X_W-1:0] spr_x,
  input  logic [NUM_SPR*X_W-1:0] spr_y,
  input  logic [NUM_SPR-1:0]     spr_en,
  input  logic [NUM_SPR*2-1:0]   spr_type,
  output logic [1:0]             rom_sel,
  output logic [7:0]             rom_addr,
  input  logic [ROM_W-1:0]       rom_data,
  input  logic [X_W-1:0]         draw_x,
  output logic                   pix_on,
  output logic [1:0]             pix_type,
  output logic                   busy,
  output logic                   overflow
);

  localparam int unsigned SLOT_W = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;

  render_state_t     state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [X_W-1:0]    y_q, y_d;
  logic [ROM_W-1:0]  shift_q, shift_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [COL_W-1:0]  width_q, width_d;
  spr_type_t         rom_sel_q, rom_sel_d;
  logic [7:0]        rom_addr_q, rom_addr_d;
  logic              busy_q, busy_d;
  logic              overflow_q, overflow_d;
  logic              complete_q, complete_d;
  logic              bank_q, bank_d;
  logic              front_valid_q, front_valid_d;

  logic [X_W-1:0]    cur_x_c;
  logic [X_W-1:0]    cur_y_c;
  spr_type_t         cur_type_c;
  logic [X_W-1:0]    row_c;
  logic              hit_c;
  logic [X_W:0]      wr_sum_c;
  logic              wr_en_c;
  lb_entry_t         wr_entry_c;
  lb_entry_t         rd_entry;

  // Current slot fields, sampled live from the sprite table.
  assign cur_x_c    = spr_x[slot_q*X_W +: X_W];
  assign cur_y_c    = spr_y[slot_q*X_W +: X_W];
  assign cur_type_c = spr_type_t'(spr_type[slot_q*2 +: 2]);
  assign row_c      = y_q - cur_y_c;
  assign hit_c      = spr_en[slot_q] && (y_q >= cur_y_c) && (row_c < X_W'(SPR_H));

  // 11-bit pixel x so sprites near the right edge clip instead of wrapping.
  assign wr_sum_c   = {1'b0, cur_x_c} + (X_W+1)'(col_q);
  assign wr_entry_c = '{valid: 1'b1, kind: rom_sel_q};

  // Next-state and output logic.
  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    y_d           = y_q;
    shift_d       = shift_q;
    col_d         = col_q;
    width_d       = width_q;
    rom_sel_d     = rom_sel_q;
    rom_addr_d    = rom_addr_q;
    busy_d        = busy_q;
    overflow_d    = 1'b0;
    complete_d    = complete_q;
    bank_d        = bank_q;
    front_valid_d = front_valid_q;
    wr_en_c       = 1'b0;

    if (line_start) begin
      // Swap banks; an unfinished render leaves the new front bank invalid.
      overflow_d    = busy_q;
      bank_d        = ~bank_q;
      front_valid_d = complete_q;
      complete_d    = 1'b0;
      y_d           = next_y;
      slot_d        = SLOT_W'(NUM_SPR - 1);
      busy_d        = 1'b1;
      state_d       = RS_EVAL;
    end else begin
      unique case (state_q)
        RS_IDLE: begin
        end
        RS_EVAL: begin
          if (hit_c) begin
            rom_sel_d  = cur_type_c;
            rom_addr_d = 8'(row_c);
            state_d    = RS_FETCH;
          end else if (slot_q == '0) begin
            state_d = RS_NEXT;
          end else begin
            slot_d  = slot_q - SLOT_W'(1);
            state_d = RS_EVAL;
          end
        end
        RS_FETCH: begin
          // Left-align the row so the leftmost pixel is always bit 15.
          shift_d = (rom_sel_q == SPR_SHIP) ? rom_data : {rom_data[7:0], 8'h00};
          col_d   = '0;
          width_d = spr_width(rom_sel_q);
          state_d = RS_WRITE;
        end
        RS_WRITE: begin
          wr_en_c = shift_q[ROM_W-1] && (wr_sum_c < (X_W+1)'(H_ACTIVE));
          shift_d = shift_q << 1;
          col_d   = col_q + COL_W'(1);
          if (col_q == width_q - COL_W'(1)) begin
            if (slot_q == '0) begin
              state_d = RS_NEXT;
            end else begin
              slot_d  = slot_q - SLOT_W'(1);
              state_d = RS_EVAL;
            end
          end
        end
        // Intermediate slot steps fold into EVAL/WRITE; only the final one
        // takes its own cycle before DONE.
        RS_NEXT: begin
          state_d = RS_DONE;
        end
        RS_DONE: begin
          busy_d     = 1'b0;
          complete_d = 1'b1;
          state_d    = RS_IDLE;
        end
        default: begin
          state_d = RS_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= RS_IDLE;
      slot_q        <= '0;
      y_q           <= '0;
      shift_q       <= '0;
      col_q         <= '0;
      width_q       <= '0;
      rom_sel_q     <= SPR_A;
      rom_addr_q    <= '0;
      busy_q        <= 1'b0;
      overflow_q    <= 1'b0;
      complete_q    <= 1'b0;
      bank_q        <= 1'b0;
      front_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      y_q           <= y_d;
      shift_q       <= shift_d;
      col_q         <= col_d;
      width_q       <= width_d;
      rom_sel_q     <= rom_sel_d;
      rom_addr_q    <= rom_addr_d;
      busy_q        <= busy_d;
      overflow_q    <= overflow_d;
      complete_q    <= complete_d;
      bank_q        <= bank_d;
      front_valid_q <= front_valid_d;
    end
  end

  sprite_line_buffer #(
    .DEPTH  (H_ACTIVE),
    .ADDR_W (LB_AW)
  ) u_lbuf (
    .clk_i      (Clk),
    .rst_ni     (Reset_n),
    .bank_sel_i (bank_q),
    .rd_en_i    (draw_x < X_W'(H_ACTIVE)),
    .rd_gate_i  (front_valid_q),
    .rd_addr_i  (draw_x),
    .rd_entry_o (rd_entry),
    .wr_en_i    (wr_en_c),
    .wr_addr_i  (wr_sum_c[LB_AW-1:0]),
    .wr_entry_i (wr_entry_c)
  );

  assign rom_sel  = rom_sel_q;
  assign rom_addr = rom_addr_q;
  assign pix_on   = rd_entry.valid;
  assign pix_type = rd_entry.kind;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_sprite_line_renderer.sv
// Self-checking bench for sprite_line_renderer: directed scenarios plus
// randomized sprite tables against a line-level behavioural model.
module tb_sprite_line_renderer;

  localparam int NS = 8;
  localparam int HA = 640;

  logic            Clk = 1'b0;
  logic            Reset_n = 1'b0;
  logic            line_start = 1'b0;
  logic [9:0]      next_y = '0;
  logic [NS*10-1:0] spr_x = '0;
  logic [NS*10-1:0] spr_y = '0;
  logic [NS-1:0]   spr_en = '0;
  logic [NS*2-1:0] spr_type = '0;
  logic [1:0]      rom_sel;
  logic [7:0]      rom_addr;
  logic [15:0]     rom_data;
  logic [9:0]      draw_x = 10'd1000;
  logic            pix_on;
  logic [1:0]      pix_type;
  logic            busy;
  logic            overflow;

  always #10 Clk = ~Clk;

  sprite_line_renderer #(.NUM_SPR(NS)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .line_start (line_start),
    .next_y     (next_y),
    .spr_x      (spr_x),
    .spr_y      (spr_y),
    .spr_en     (spr_en),
    .spr_type   (spr_type),
    .rom_sel    (rom_sel),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .draw_x     (draw_x),
    .pix_on     (pix_on),
    .pix_type   (pix_type),
    .busy       (busy),
    .overflow   (overflow)
  );

  // ROM contents: [type][row], enemy rows are 8 bits zero-extended.
  logic [15:0] rom_mem [4][8];
  always_comb rom_data = (rom_addr < 8'd8) ? rom_mem[rom_sel][rom_addr[2:0]] : 16'h0000;

  // Sprite table as the bench sees it.
  int sx [NS];
  int sy [NS];
  int st [NS];
  bit sen [NS];

  int n_cmp = 0;
  int n_err = 0;
  bit armed = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit rv [HA];     // line produced by the render in flight
  int rt [HA];
  bit dv [HA];     // line currently on display
  int dt [HA];
  bit disp_valid;
  int s;           // clock edges since the last render started (0 = none yet)
  int D;           // cycles the last render keeps busy high
  bit exp_ovf, exp_on;
  int exp_type;

  task automatic model_render(input int y);
    int w, row, bits, px;
    D = 2;
    for (int i = 0; i < HA; i++) begin rv[i] = 0; rt[i] = 0; end
    for (int sl = NS - 1; sl >= 0; sl--) begin
      row = y - sy[sl];
      if (sen[sl] && row >= 0 && row < 8) begin
        w    = (st[sl] == 3) ? 16 : 8;
        bits = int'(rom_mem[st[sl]][row]);
        D   += 2 + w;
        for (int c = 0; c < w; c++) begin
          px = sx[sl] + c;
          if (bits[w-1-c] && px < HA) begin rv[px] = 1; rt[px] = st[sl]; end
        end
      end else begin
        D += 1;
      end
    end
  endtask

  // Compare process: check last cycle's expectations, then predict the next.
  always @(negedge Clk) begin
    if (!Reset_n) begin
      s = 0; D = 0; exp_ovf = 0; exp_on = 0; exp_type = 0; disp_valid = 0;
    end else begin
      if (armed) begin
        check("busy", int'(busy), int'(s >= 1 && s <= D));
        check("overflow", int'(overflow), int'(exp_ovf));
        check("pix_on", int'(pix_on), int'(exp_on));
        if (exp_on) check("pix_type", int'(pix_type), exp_type);
      end
      exp_ovf = line_start && (s >= 1 && s <= D);
      if (draw_x < 10'(HA)) begin
        exp_on   = disp_valid && dv[draw_x];
        exp_type = dt[draw_x];
        dv[draw_x] = 0;
      end else begin
        exp_on = 0;
      end
      if (line_start) begin
        disp_valid = (s > D);
        for (int i = 0; i < HA; i++) begin dv[i] = rv[i]; dt[i] = rt[i]; end
        model_render(int'(next_y));
        s = 1;
      end else if (s > 0 && s < 1000000) begin
        s++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  bit cap_on [HA];
  int cap_type [HA];
  int busy_cnt, ovf_cnt;
  bit saw_row;

  task automatic apply_table();
    for (int i = 0; i < NS; i++) begin
      spr_x[10*i +: 10]  = 10'(sx[i]);
      spr_y[10*i +: 10]  = 10'(sy[i]);
      spr_type[2*i +: 2] = 2'(st[i]);
      spr_en[i]          = sen[i];
    end
  endtask

  task automatic clear_table();
    for (int i = 0; i < NS; i++) begin sx[i] = 0; sy[i] = 0; st[i] = 0; sen[i] = 0; end
  endtask

  // Pulse line_start for line y, then sweep draw_x for ncyc cycles.
  task automatic run_line(input int y, input int ncyc);
    @(posedge Clk); #1;
    apply_table();
    next_y = 10'(y);
    line_start = 1'b1;
    @(posedge Clk); #1;
    line_start = 1'b0;
    busy_cnt = int'(busy);
    ovf_cnt  = int'(overflow);
    saw_row  = 0;
    for (int x = 0; x < ncyc; x++) begin
      draw_x = (x < 661) ? 10'(x) : 10'd1000;
      @(posedge Clk); #1;
      if (x < HA) begin cap_on[x] = pix_on; cap_type[x] = int'(pix_type); end
      busy_cnt += int'(busy);
      ovf_cnt  += int'(overflow);
      if (busy && rom_sel == 2'd3 && rom_addr == 8'd4) saw_row = 1;
    end
    draw_x = 10'd1000;
  endtask

  function automatic int ones();
    int n = 0;
    for (int i = 0; i < HA; i++) n += int'(cap_on[i]);
    return n;
  endfunction

  function automatic bit in_ship_pattern(input int x);
    // 0100110110110010 placed at x=100
    return x == 101 || x == 104 || x == 105 || x == 107 || x == 108 ||
           x == 110 || x == 111 || x == 114;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    for (int t = 0; t < 4; t++)
      for (int r = 0; r < 8; r++)
        rom_mem[t][r] = (t == 3) ? 16'($urandom) : {8'h00, 8'($urandom)};
    rom_mem[3][4] = 16'h4DB2;
    rom_mem[0][3] = 16'h00A5;
    rom_mem[1][3] = 16'h00FF;
    rom_mem[2][0] = 16'h0018;
    clear_table();

    repeat (3) @(posedge Clk);
    #1;
    check("rst_pix_on", int'(pix_on), 0);
    check("rst_pix_type", int'(pix_type), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_rom_sel", int'(rom_sel), 0);
    check("rst_rom_addr", int'(rom_addr), 0);
    Reset_n = 1'b1;
    armed = 1;

    // Empty the initial front bank.
    for (int x = 0; x < HA; x++) begin draw_x = 10'(x); @(posedge Clk); #1; end
    draw_x = 10'd1000;

    // L1: no sprites enabled; first swap leaves front invalid.
    run_line(0, 661);
    check("empty_busy_cycles", busy_cnt, 10);
    check("first_line_dark", ones(), 0);

    // L2: ship in slot 0, row 4.
    clear_table();
    sx[0] = 100; sy[0] = 50; st[0] = 3; sen[0] = 1;
    run_line(54, 661);
    check("ship_rom_sel3_addr4", int'(saw_row), 1);

    // L3: A in slot 3, B in slot 1 overlapping; display the ship line.
    clear_table();
    sx[3] = 200; sy[3] = 10; st[3] = 0; sen[3] = 1;
    sx[1] = 200; sy[1] = 10; st[1] = 1; sen[1] = 1;
    run_line(13, 661);
    for (int x = 95; x < 121; x++) check($sformatf("ship_px%0d", x), int'(cap_on[x]), int'(in_ship_pattern(x)));
    check("ship_type", cap_type[101], 3);
    check("ship_count", ones(), 8);

    // L4: C near the right edge; display the overlap line.
    clear_table();
    sx[0] = 636; sy[0] = 0; st[0] = 2; sen[0] = 1;
    run_line(0, 661);
    for (int x = 200; x < 208; x++) begin
      check($sformatf("prio_on%0d", x), int'(cap_on[x]), 1);
      check($sformatf("prio_type%0d", x), cap_type[x], 1);
    end

    // L5: empty render; display the clipped line.
    clear_table();
    run_line(0, 661);
    check("clip_639_on", int'(cap_on[639]), 1);
    check("clip_639_type", cap_type[639], 2);
    for (int x = 0; x < 4; x++) check($sformatf("nowrap_px%0d", x), int'(cap_on[x]), 0);
    check("clip_count", ones(), 1);

    // L6/L7: full 8-slot ship render aborted after 50 cycles, then restarted.
    for (int i = 0; i < NS; i++) begin sx[i] = 10 + 70 * i; sy[i] = 100; st[i] = 3; sen[i] = 1; end
    run_line(104, 50);
    check("no_ovf_from_idle", ovf_cnt, 0);
    run_line(104, 661);
    check("ovf_pulses", ovf_cnt, 1);
    check("aborted_line_dark", ones(), 0);

    // Randomized lines; L8 displays the restarted full render first.
    for (int n = 0; n < 16; n++) begin
      int ny;
      ny = int'($urandom_range(0, 479));
      for (int i = 0; i < NS; i++) begin
        sen[i] = ($urandom_range(0, 3) != 0);
        st[i]  = int'($urandom_range(0, 3));
        sx[i]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(600, 1023)) : int'($urandom_range(0, 639));
        sy[i]  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 1023)) : ny - int'($urandom_range(0, 9));
        if (sy[i] < 0) sy[i] = 0;
      end
      run_line(ny, 661);
      if (n == 0) check("full_render_count", ones(), 64);
    end

    // Two empty renders: the second displayed line proves the bank was cleared.
    clear_table();
    run_line(5, 661);
    run_line(5, 661);
    check("cleared_bank_dark", ones(), 0);

    repeat (4) @(posedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
